// File: rtl/rotate_commit.sv
// Commit stage behind the combinational Rotate block. It holds the falling
// piece, checks each rotation candidate against the walls, floor and board, then commits or rejects it.
module rotate_commit #(
  parameter int W  = 10,
  parameter int H  = 20,
  parameter int AW = 5,
  parameter int XW = 5,
  parameter int YW = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load_valid,
  input  logic [0:15]          load_float,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_dir,
  input  logic signed [XW-1:0] pos_x,
  input  logic signed [YW-1:0] pos_y,
  output logic [0:15]          rot_float_o,
  output logic                 rot_dir_o,
  input  logic [0:15]          rot_new_i,
  output logic                 row_rd,
  output logic [AW-1:0]        row_addr,
  input  logic [0:W-1]         row_data,
  output logic [0:15]          float_out,
  output logic                 resp_valid,
  output logic                 resp_ok
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {IDLE, FETCH, LAST, RESP} state_t;

  state_t                state_q, state_d;
  logic [1:0]            idx_q, idx_d;
  logic [0:15]           float_q, float_d;
  logic [0:15]           rfloat_q, rfloat_d;
  logic                  rdir_q, rdir_d;
  logic signed [XW-1:0]  px_q, px_d;
  logic signed [YW-1:0]  py_q, py_d;
  logic                  collide_q, collide_d;

  logic signed [YW:0]    issue_y;
  logic signed [YW:0]    cmp_y;
  logic [1:0]            cmp_idx;
  logic                  cmp_en;
  logic [3:0]            cell_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      float_q   <= '0;
      rfloat_q  <= '0;
      rdir_q    <= 1'b0;
      px_q      <= '0;
      py_q      <= '0;
      collide_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      float_q   <= float_d;
      rfloat_q  <= rfloat_d;
      rdir_q    <= rdir_d;
      px_q      <= px_d;
      py_q      <= py_d;
      collide_q <= collide_d;
    end
  end

  // Row being fetched this cycle, and the row whose data is arriving now.
  always_comb begin
    issue_y = $signed({py_q[YW-1], py_q}) + $signed({{(YW-1){1'b0}}, idx_q});
    cmp_idx = (state_q == LAST) ? 2'd3 : (idx_q - 2'd1);
    cmp_en  = ((state_q == FETCH) && (idx_q != 2'd0)) || (state_q == LAST);
    cmp_y   = $signed({py_q[YW-1], py_q}) + $signed({{(YW-1){1'b0}}, cmp_idx});
  end

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_col
      logic signed [XW:0] cell_x;
      logic               in_x;
      logic [CW-1:0]      cell_xi;
      assign cell_x  = $signed({px_q[XW-1], px_q}) + $signed((XW+1)'(gi));
      assign in_x    = (cell_x >= 0) && (cell_x < W);
      assign cell_xi = cell_x[CW-1:0];
      // Rows above the board only get the wall check; the board bit is consulted only for on-board rows.
      assign cell_hit[gi] = rot_new_i[{cmp_idx, 2'(gi)}] &&
                            (!in_x || (cmp_y >= H) || ((cmp_y >= 0) && row_data[cell_xi]));
    end
  endgenerate

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    float_d   = float_q;
    rfloat_d  = rfloat_q;
    rdir_d    = rdir_q;
    px_d      = px_q;
    py_d      = py_q;
    collide_d = collide_q;
    row_rd    = 1'b0;
    row_addr  = '0;

    case (state_q)
      IDLE: begin
        if (load_valid) begin
          float_d = load_float;
        end else if (req_valid) begin
          rfloat_d  = float_q;
          rdir_d    = req_dir;
          px_d      = pos_x;
          py_d      = pos_y;
          idx_d     = 2'd0;
          collide_d = 1'b0;
          state_d   = FETCH;
        end
      end
      FETCH: begin
        if ((issue_y >= 0) && (issue_y < H)) begin
          row_rd   = 1'b1;
          row_addr = issue_y[AW-1:0];
        end
        if (cmp_en) collide_d = collide_q | (|cell_hit);
        idx_d = idx_q + 2'd1;
        if (idx_q == 2'd3) state_d = LAST;
      end
      LAST: begin
        collide_d = collide_q | (|cell_hit);
        state_d   = RESP;
      end
      RESP: begin
        if (!collide_q) float_d = rot_new_i;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign req_ready   = (state_q == IDLE);
  assign resp_valid  = (state_q == RESP);
  assign resp_ok     = (state_q == RESP) && !collide_q;
  assign rot_float_o = rfloat_q;
  assign rot_dir_o   = rdir_q;
  assign float_out   = float_q;

endmodule

// File: tb/tb_rotate_commit.sv
// Scoreboard bench for rotate_commit: a board RAM model answers row reads, and
// expected read addresses and responses are queued at request time.
module tb_rotate_commit;
  localparam int W = 10, H = 20, AW = 5, XW = 5, YW = 6;

  logic clk = 1'b0, rst_n = 1'b0;
  logic load_valid = 1'b0, req_valid = 1'b0, req_dir = 1'b0;
  logic [0:15] load_float = '0, rot_new_i = '0;
  logic signed [XW-1:0] pos_x = '0;
  logic signed [YW-1:0] pos_y = '0;
  logic req_ready, rot_dir_o, row_rd, resp_valid, resp_ok;
  logic [0:15] rot_float_o, float_out;
  logic [AW-1:0] row_addr;
  logic [0:W-1] row_data = '0;

  logic [0:W-1] board [H];
  int addr_q[$];
  logic ok_q[$];
  int total = 0, bad = 0, pulses = 0;
  bit mon_en = 1'b1;
  logic [0:15] cur_float = '0;

  rotate_commit #(.W(W), .H(H), .AW(AW), .XW(XW), .YW(YW)) dut (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_float(load_float),
    .req_valid(req_valid), .req_ready(req_ready), .req_dir(req_dir),
    .pos_x(pos_x), .pos_y(pos_y), .rot_float_o(rot_float_o), .rot_dir_o(rot_dir_o),
    .rot_new_i(rot_new_i), .row_rd(row_rd), .row_addr(row_addr), .row_data(row_data),
    .float_out(float_out), .resp_valid(resp_valid), .resp_ok(resp_ok)
  );

  always #5 clk = ~clk;

  // Board RAM with one-cycle read latency; returns all-ones when not read so stray board checks show up.
  always @(posedge clk)
    row_data <= (row_rd && (int'(row_addr) < H)) ? board[row_addr] : {W{1'b1}};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && resp_valid) pulses++;
    if (rst_n && mon_en) begin
      if (row_rd) begin
        if (addr_q.size() == 0) check("rd_extra", 32'(row_addr), 32'hFFFF);
        else check("row_addr", 32'(row_addr), 32'(addr_q.pop_front()));
      end
      if (resp_valid) begin
        if (ok_q.size() == 0) check("resp_extra", 1, 0);
        else check("resp_ok", 32'(resp_ok), 32'(ok_q.pop_front()));
      end
    end
  end

  function automatic logic model_ok(input int px, input int py, input logic [0:15] nf);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (nf[4*r+c]) begin
          int x = px + c;
          int y = py + r;
          if (x < 0 || x >= W || y >= H) return 1'b0;
          if (y >= 0 && board[y][x]) return 1'b0;
        end
    return 1'b1;
  endfunction

  task automatic clear_board();
    for (int y = 0; y < H; y++) board[y] = '0;
  endtask

  task automatic do_load(input logic [0:15] f);
    load_valid = 1'b1;
    load_float = f;
    @(posedge clk); #1;
    load_valid = 1'b0;
    cur_float  = f;
    check("load", 32'(float_out), 32'(f));
  endtask

  task automatic do_rot(input string tag, input int px, input int py, input logic [0:15] nf,
                        input logic exp_ok, input bit poke);
    int n;
    int p0;
    logic [0:15] exp_f;
    p0    = pulses;
    exp_f = exp_ok ? nf : cur_float;
    for (int i = 0; i < 4; i++)
      if (py + i >= 0 && py + i < H) addr_q.push_back(py + i);
    ok_q.push_back(exp_ok);
    check({tag, "_ready"}, 32'(req_ready), 1);
    req_valid = 1'b1;
    req_dir   = poke;
    pos_x     = XW'(px);
    pos_y     = YW'(py);
    rot_new_i = nf;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 1;
    check({tag, "_rotf"}, 32'(rot_float_o), 32'(cur_float));
    while (!resp_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
      req_valid  = poke && n >= 2 && n <= 5;
      load_valid = poke && n >= 2 && n <= 5;
      load_float = 16'hFFFF;
      if (n == 3) check({tag, "_busy"}, 32'(req_ready), 0);
    end
    req_valid  = 1'b0;
    load_valid = 1'b0;
    check({tag, "_lat"}, 32'(n), 6);
    @(posedge clk); #1;
    check({tag, "_float"}, 32'(float_out), 32'(exp_f));
    cur_float = exp_f;
    repeat (8) @(posedge clk);
    #1;
    check({tag, "_pulses"}, 32'(pulses - p0), 1);
    $display("tx %s px=%0d py=%0d new=%h exp_ok=%0b", tag, px, py, nf, exp_ok);
  endtask

  initial begin
    int p0;
    clear_board();
    repeat (2) @(posedge clk);
    #1;
    check("rst_float", 32'(float_out), 0);
    check("rst_rd", 32'(row_rd), 0);
    check("rst_resp", 32'(resp_valid), 0);
    check("rst_ready", 32'(req_ready), 1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_load(16'h4444);
    do_rot("empty", 3, 5, 16'h0F00, 1'b1, 1'b0);
    do_load(16'h4444);
    do_rot("wall_l", -1, 5, 16'h0F00, 1'b0, 1'b0);
    board[6][4] = 1'b1;
    do_rot("board", 3, 5, 16'h0F00, 1'b0, 1'b0);
    clear_board();
    do_rot("floor", 3, 18, 16'h00E0, 1'b0, 1'b0);
    do_rot("above", 3, -2, 16'h00E0, 1'b1, 1'b0);
    do_rot("wall_r", 7, 4, 16'h00F0, 1'b0, 1'b0);
    do_rot("blank", -4, 25, 16'h0000, 1'b1, 1'b0);

    for (int k = 0; k < 8; k++) begin
      int px, py;
      logic [0:15] nf;
      for (int y = 0; y < H; y++) board[y] = W'($urandom) & W'($urandom) & W'($urandom);
      px = int'($urandom_range(0, 10)) - 2;
      py = int'($urandom_range(0, 21)) - 3;
      nf = 16'($urandom) & 16'($urandom);
      do_rot($sformatf("rnd%0d", k), px, py, nf, model_ok(px, py, nf), 1'b0);
    end
    clear_board();

    do_rot("poke", 2, 2, 16'h0660, 1'b1, 1'b1);

    p0 = pulses;
    load_valid = 1'b1; req_valid = 1'b1; load_float = 16'h0F0F;
    pos_x = 5'sd3; pos_y = 6'sd5;
    @(posedge clk); #1;
    load_valid = 1'b0; req_valid = 1'b0;
    check("ld_req_float", 32'(float_out), 32'h0F0F);
    check("ld_req_ready", 32'(req_ready), 1);
    repeat (8) @(posedge clk);
    #1;
    check("ld_req_pulses", 32'(pulses - p0), 0);
    cur_float = 16'h0F0F;
    $display("tx ld_req float=%h", float_out);

    mon_en = 1'b0;
    p0 = pulses;
    req_valid = 1'b1; pos_x = 5'sd3; pos_y = 6'sd5; rot_new_i = 16'h0F00;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_float", 32'(float_out), 0);
    check("arst_rd", 32'(row_rd), 0);
    check("arst_addr", 32'(row_addr), 0);
    check("arst_rotf", 32'(rot_float_o), 0);
    check("arst_resp", 32'({resp_valid, resp_ok}), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check("arst_pulses", 32'(pulses - p0), 0);
    check("arst_ready", 32'(req_ready), 1);
    check("arst_hold", 32'(float_out), 0);
    $display("tx async_reset float=%h", float_out);
    mon_en = 1'b1;

    check("addr_left", 32'(addr_q.size()), 0);
    check("resp_left", 32'(ok_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got=running exp=finished");
    $fatal(1);
  end
endmodule
